// File: rtl/ee354_ssd_decoder.sv
// ee354_ssd_decoder: receive-side monitor for a multiplexed, active-low
// seven-segment interface. It waits for each scanned digit to hold steady,
// decodes the cathode pattern back to a hex digit, and rebuilds the
// displayed decimal value once all four positions of a frame are captured.
module ee354_ssd_decoder #(
    parameter int N_STABLE = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  An,
    input  logic [7:0]  Cath,
    output logic [3:0]  Digit3,
    output logic [3:0]  Digit2,
    output logic [3:0]  Digit1,
    output logic [3:0]  Digit0,
    output logic [13:0] Value,
    output logic        Frame_Valid,
    output logic        Bcd_Err,
    output logic        Seg_Err,
    output logic        Anode_Err,
    output logic        Err_Sticky
);

    localparam int CW = $clog2(N_STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_STABLE);

    // Map a Ca..Cg pattern to {hit, hex}; hit=0 for anything not in the table.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: seg_decode = 5'b1_0000;
            7'b1001111: seg_decode = 5'b1_0001;
            7'b0010010: seg_decode = 5'b1_0010;
            7'b0000110: seg_decode = 5'b1_0011;
            7'b1001100: seg_decode = 5'b1_0100;
            7'b0100100: seg_decode = 5'b1_0101;
            7'b0100000: seg_decode = 5'b1_0110;
            7'b0001111: seg_decode = 5'b1_0111;
            7'b0000000: seg_decode = 5'b1_1000;
            7'b0000100: seg_decode = 5'b1_1001;
            7'b0001000: seg_decode = 5'b1_1010;
            7'b1100000: seg_decode = 5'b1_1011;
            7'b0110001: seg_decode = 5'b1_1100;
            7'b1000010: seg_decode = 5'b1_1101;
            7'b0110000: seg_decode = 5'b1_1110;
            7'b0111000: seg_decode = 5'b1_1111;
            default:    seg_decode = 5'b0_0000;
        endcase
    endfunction

    logic [11:0]   r_prev;
    logic [CW-1:0] r_cnt;
    logic          r_dwell_done;
    logic [3:0]    r_mask;
    logic [3:0]    r_digit3, r_digit2, r_digit1, r_digit0;
    logic [13:0]   r_value;
    logic          r_frame_valid, r_bcd_err, r_seg_err, r_anode_err, r_err_sticky;

    logic [11:0]   w_cur;
    logic          w_same;
    logic          w_sample;
    logic [3:0]    w_an_low;
    logic          w_one_low;
    logic          w_blank;
    logic [4:0]    w_dec;
    logic [3:0]    w_cap_bit;
    logic          w_seg_err;
    logic          w_anode_err;
    logic          w_complete;
    logic          w_all_bcd;
    logic [13:0]   w_value;

    assign w_cur     = {An, Cath};
    assign w_same    = (w_cur == r_prev);
    // One sample per dwell: the counter has saturated and this dwell has not fired yet.
    assign w_sample  = w_same && (r_cnt == CNT_MAX) && !r_dwell_done;
    assign w_an_low  = ~An;
    assign w_blank   = (An == 4'b1111);
    assign w_one_low = !w_blank && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);
    assign w_dec     = seg_decode(Cath[7:1]);

    // Completion looks at the mask from before this edge, so a capture landing
    // on the same edge starts the next frame instead of being lost.
    assign w_complete = (r_mask == 4'b1111);
    assign w_all_bcd  = (r_digit3 <= 4'd9) && (r_digit2 <= 4'd9) &&
                        (r_digit1 <= 4'd9) && (r_digit0 <= 4'd9);
    assign w_value    = ({10'd0, r_digit3} * 14'd1000) + ({10'd0, r_digit2} * 14'd100) +
                        ({10'd0, r_digit1} * 14'd10)   +  {10'd0, r_digit0};

    // Classify the sample event into capture / segment error / anode error.
    always_comb begin
        w_cap_bit   = 4'd0;
        w_seg_err   = 1'b0;
        w_anode_err = 1'b0;
        if (w_sample) begin
            if (w_blank) begin
                w_cap_bit = 4'd0;
            end else if (w_one_low) begin
                if (w_dec[4]) begin
                    w_cap_bit = w_an_low;
                end else begin
                    w_seg_err = 1'b1;
                end
            end else begin
                w_anode_err = 1'b1;
            end
        end else begin
            w_cap_bit = 4'd0;
        end
    end

    // Input history and stability counter that gates sampling.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_prev       <= 12'd0;
            r_cnt        <= '0;
            r_dwell_done <= 1'b0;
        end else begin
            r_prev <= w_cur;
            if (!w_same) begin
                r_cnt        <= '0;
                r_dwell_done <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_sample) begin
                    r_dwell_done <= 1'b1;
                end
            end
        end
    end

    // Digit capture, frame assembly, value reconstruction and error flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_digit3      <= 4'd0;
            r_digit2      <= 4'd0;
            r_digit1      <= 4'd0;
            r_digit0      <= 4'd0;
            r_mask        <= 4'd0;
            r_value       <= 14'd0;
            r_frame_valid <= 1'b0;
            r_bcd_err     <= 1'b0;
            r_seg_err     <= 1'b0;
            r_anode_err   <= 1'b0;
            r_err_sticky  <= 1'b0;
        end else begin
            if (w_cap_bit[3]) r_digit3 <= w_dec[3:0];
            if (w_cap_bit[2]) r_digit2 <= w_dec[3:0];
            if (w_cap_bit[1]) r_digit1 <= w_dec[3:0];
            if (w_cap_bit[0]) r_digit0 <= w_dec[3:0];
            r_mask        <= (w_complete ? 4'd0 : r_mask) | w_cap_bit;
            r_frame_valid <= w_complete;
            r_bcd_err     <= w_complete && !w_all_bcd;
            if (w_complete && w_all_bcd) begin
                r_value <= w_value;
            end
            r_seg_err    <= w_seg_err;
            r_anode_err  <= w_anode_err;
            r_err_sticky <= r_err_sticky | r_seg_err | r_anode_err;
        end
    end

    assign Digit3      = r_digit3;
    assign Digit2      = r_digit2;
    assign Digit1      = r_digit1;
    assign Digit0      = r_digit0;
    assign Value       = r_value;
    assign Frame_Valid = r_frame_valid;
    assign Bcd_Err     = r_bcd_err;
    assign Seg_Err     = r_seg_err;
    assign Anode_Err   = r_anode_err;
    assign Err_Sticky  = r_err_sticky;

endmodule

// File: tb/tb_ee354_ssd_decoder.sv
// Directed bench for ee354_ssd_decoder with N_STABLE = 4.
// Inputs change just after falling edges; outputs are read on falling edges.
module tb_ee354_ssd_decoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  An;
    logic [7:0]  Cath;
    logic [3:0]  Digit3, Digit2, Digit1, Digit0;
    logic [13:0] Value;
    logic        Frame_Valid, Bcd_Err, Seg_Err, Anode_Err, Err_Sticky;

    int n_cmp  = 0;
    int n_fail = 0;
    int fv_cnt = 0, bcd_cnt = 0, both_cnt = 0, seg_cnt = 0, an_cnt = 0;

    // Ca..Cg patterns for hex 0..F, active-low.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    ee354_ssd_decoder #(.N_STABLE(4)) dut (
        .Clk(Clk), .Reset(Reset), .An(An), .Cath(Cath),
        .Digit3(Digit3), .Digit2(Digit2), .Digit1(Digit1), .Digit0(Digit0),
        .Value(Value), .Frame_Valid(Frame_Valid), .Bcd_Err(Bcd_Err),
        .Seg_Err(Seg_Err), .Anode_Err(Anode_Err), .Err_Sticky(Err_Sticky)
    );

    always #5 Clk = ~Clk;

    // Pulse counters, sampled shortly after each rising edge.
    always begin
        @(posedge Clk);
        #2;
        if (Frame_Valid) fv_cnt++;
        if (Bcd_Err) bcd_cnt++;
        if (Frame_Valid && Bcd_Err) both_cnt++;
        if (Seg_Err) seg_cnt++;
        if (Anode_Err) an_cnt++;
    end

    task automatic drive(input logic [3:0] an, input logic [7:0] cath, input int n);
        An = an;
        Cath = cath;
        repeat (n) @(negedge Clk);
    endtask

    task automatic show(input int pos, input int d, input int n);
        drive(~(4'b0001 << pos), {SEG_TAB[d], 1'b1}, n);
    endtask

    task automatic frame(input int d3, input int d2, input int d1, input int d0);
        show(3, d3, 8);
        show(2, d2, 8);
        show(1, d1, 8);
        show(0, d0, 8);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        An = 4'b1111;
        Cath = 8'hFF;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({Digit3, Digit2, Digit1, Digit0, Value, Frame_Valid, Bcd_Err, Seg_Err, Anode_Err, Err_Sticky} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_during: outputs %h, required 0", {Digit3, Digit2, Digit1, Digit0, Value, Frame_Valid, Bcd_Err, Seg_Err, Anode_Err, Err_Sticky});
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({Digit3, Digit2, Digit1, Digit0, Value, Frame_Valid, Bcd_Err, Seg_Err, Anode_Err, Err_Sticky} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_after: outputs %h, required 0", {Digit3, Digit2, Digit1, Digit0, Value, Frame_Valid, Bcd_Err, Seg_Err, Anode_Err, Err_Sticky});
        end
    endtask

    task automatic test_basic();
        int fv0, e0;
        fv0 = fv_cnt;
        e0 = seg_cnt + an_cnt;
        show(3, 0, 8);
        show(2, 0, 8);
        show(1, 0, 8);
        An = 4'b1110;
        Cath = {SEG_TAB[3], 1'b1};
        repeat (5) @(negedge Clk);
        n_cmp++;
        if (Digit0 !== 4'd0) begin n_fail++; $display("FAIL latency_early: Digit0 %0d, required 0", Digit0); end
        @(negedge Clk);
        n_cmp++;
        if (Digit0 !== 4'd3 || Frame_Valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_capture: Digit0 %0d FV %b, required 3 0", Digit0, Frame_Valid);
        end
        @(negedge Clk);
        n_cmp++;
        if (Frame_Valid !== 1'b1 || Value !== 14'd3) begin
            n_fail++; $display("FAIL frame_pulse: FV %b Value %0d, required 1 3", Frame_Valid, Value);
        end
        @(negedge Clk);
        n_cmp++;
        if (Frame_Valid !== 1'b0) begin n_fail++; $display("FAIL frame_one_cycle: FV %b, required 0", Frame_Valid); end
        repeat (4) @(negedge Clk);
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || seg_cnt + an_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL basic_counts: frames %0d errs %0d, required 1 0", fv_cnt - fv0, seg_cnt + an_cnt - e0);
        end
    endtask

    task automatic test_value_update();
        frame(0, 2, 2, 5);
        n_cmp++;
        if (Value !== 14'd225) begin n_fail++; $display("FAIL value_225: Value %0d, required 225", Value); end
        frame(0, 2, 2, 6);
        n_cmp++;
        if (Value !== 14'd226) begin n_fail++; $display("FAIL value_226: Value %0d, required 226", Value); end
    endtask

    task automatic test_short_dwell();
        int fv0;
        fv0 = fv_cnt;
        show(3, 0, 8);
        show(2, 1, 8);
        show(1, 4, 4);
        show(0, 7, 8);
        n_cmp++;
        if (Digit1 !== 4'd2 || fv_cnt - fv0 !== 0) begin
            n_fail++; $display("FAIL short_dwell: Digit1 %0d frames %0d, required 2 0", Digit1, fv_cnt - fv0);
        end
        show(1, 4, 8);
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || Value !== 14'd147) begin
            n_fail++; $display("FAIL long_dwell: frames %0d Value %0d, required 1 147", fv_cnt - fv0, Value);
        end
    endtask

    task automatic test_seg_anode();
        int fv0, s0, a0;
        fv0 = fv_cnt;
        s0 = seg_cnt;
        a0 = an_cnt;
        show(3, 0, 8);
        show(2, 2, 8);
        show(1, 2, 8);
        drive(4'b1110, 8'hFF, 8);
        n_cmp++;
        if (seg_cnt - s0 !== 1 || Err_Sticky !== 1'b1 || fv_cnt - fv0 !== 0) begin
            n_fail++; $display("FAIL seg_err: pulses %0d sticky %b frames %0d, required 1 1 0", seg_cnt - s0, Err_Sticky, fv_cnt - fv0);
        end
        drive(4'b1100, {SEG_TAB[8], 1'b1}, 8);
        n_cmp++;
        if (an_cnt - a0 !== 1 || fv_cnt - fv0 !== 0) begin
            n_fail++; $display("FAIL anode_err: pulses %0d frames %0d, required 1 0", an_cnt - a0, fv_cnt - fv0);
        end
        show(0, 5, 8);
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || Value !== 14'd225 || Err_Sticky !== 1'b1) begin
            n_fail++; $display("FAIL after_errs: frames %0d Value %0d sticky %b, required 1 225 1", fv_cnt - fv0, Value, Err_Sticky);
        end
    endtask

    task automatic test_bcd();
        int fv0, b0, c0;
        fv0 = fv_cnt;
        b0 = bcd_cnt;
        c0 = both_cnt;
        frame(0, 0, 1, 10);
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || bcd_cnt - b0 !== 1 || both_cnt - c0 !== 1) begin
            n_fail++; $display("FAIL bcd_pulse: fv %0d bcd %0d together %0d, required 1 1 1", fv_cnt - fv0, bcd_cnt - b0, both_cnt - c0);
        end
        n_cmp++;
        if (Value !== 14'd225 || Digit0 !== 4'hA) begin
            n_fail++; $display("FAIL bcd_hold: Value %0d Digit0 %0d, required 225 10", Value, Digit0);
        end
    endtask

    task automatic test_reset_midframe();
        int fv0;
        show(3, 1, 8);
        show(2, 2, 8);
        Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (Digit3 !== 4'd0 || Value !== 14'd0 || Err_Sticky !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: Digit3 %0d Value %0d sticky %b, required 0 0 0", Digit3, Value, Err_Sticky);
        end
        Reset = 1'b0;
        fv0 = fv_cnt;
        show(1, 3, 8);
        show(0, 4, 8);
        n_cmp++;
        if (fv_cnt - fv0 !== 0) begin n_fail++; $display("FAIL mask_cleared: frames %0d, required 0", fv_cnt - fv0); end
        show(3, 9, 8);
        show(2, 8, 8);
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || Value !== 14'd9834) begin
            n_fail++; $display("FAIL new_frame: frames %0d Value %0d, required 1 9834", fv_cnt - fv0, Value);
        end
    endtask

    // Scenario sequence.
    initial begin
        Reset = 1'b1;
        An = 4'b1111;
        Cath = 8'hFF;
        @(negedge Clk);
        test_reset();
        test_basic();
        test_value_update();
        test_short_dwell();
        test_seg_anode();
        test_bcd();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
